// File: rtl/reg_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter_pkg
//   Shared bus definitions for the register-file write-back path.
//   Holds the register address and data widths and the default port
//   geometry used by reg_write_arbiter and its round-robin picker.
//   Also defines the packed write-back beat type held in the output
//   register.
// ---------------------------------------------------------------------------
package reg_write_arbiter_pkg;

    localparam int REG_ADDR_W        = 5;
    localparam int DATA_W            = 32;
    localparam int NUM_PORTS_DEFAULT = 3;
    localparam int PORT_ID_W_DEFAULT = 2;

    // One register-file write beat.
    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_beat_t;

    // Register 0 is hard-wired: writes to it are accepted but discarded.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Purely combinational round-robin selector.
//   Ports:
//     req        in   NUM_PORTS  per-port request vector
//     last_grant in   PORT_ID_W  index of the previous winner
//     grant      out  NUM_PORTS  one-hot winner (all zero if no request)
//     grant_idx  out  PORT_ID_W  binary index of the winner
//     grant_any  out  1          at least one request present
//   The search starts at (last_grant + 1) mod NUM_PORTS and wraps; the
//   first requesting port found wins.
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_PORTS = 3,
    parameter int PORT_ID_W = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_ID_W-1:0] last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PORT_ID_W-1:0] grant_idx,
    output logic                 grant_any
);

    logic [PORT_ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        // Offsets 1..NUM_PORTS visit every port once, ending on last_grant
        // itself so a lone repeat requester still wins.
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = PORT_ID_W'((32'(last_grant) + 32'(i)) % 32'(NUM_PORTS));
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//   Round-robin arbiter merging several write-back requesters onto one
//   register-file write port, with a registered output stage and a
//   combinational read-after-write hazard check for the decode stage.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     req_valid/req_ready      per-port handshake (NUM_PORTS each)
//     req_addr                 packed 5-bit addresses, port k at [5k+4:5k]
//     req_data                 packed 32-bit data, port k at [32k+31:32k]
//     write_en/addr/data       register-file write port (1-cycle latency)
//     grant_id                 port whose write is on write_*
//     query_addr_1/2           decode-stage source addresses
//     query_hit_1/2            pending write to that address exists
//
//   Handshake: a transfer on port k happens at a rising edge where
//   req_valid[k] && req_ready[k]. req_ready is a function of req_valid and
//   the round-robin pointer only (never of address or data), at most one
//   bit is high, and it is forced low while rst is high. A requester keeps
//   valid/addr/data stable until accepted.
// ---------------------------------------------------------------------------
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEFAULT,
    parameter int PORT_ID_W = PORT_ID_W_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS*REG_ADDR_W-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]      req_data,
    output logic                             write_en,
    output logic [REG_ADDR_W-1:0]            write_addr,
    output logic [DATA_W-1:0]                write_data,
    output logic [PORT_ID_W-1:0]             grant_id,
    input  logic [REG_ADDR_W-1:0]            query_addr_1,
    input  logic [REG_ADDR_W-1:0]            query_addr_2,
    output logic                             query_hit_1,
    output logic                             query_hit_2
);

    localparam logic [PORT_ID_W-1:0] LAST_GRANT_RST = PORT_ID_W'(NUM_PORTS - 1);

    logic [PORT_ID_W-1:0]  last_grant_q, last_grant_d;
    wb_beat_t              wb_q, wb_d;
    logic [PORT_ID_W-1:0]  grant_id_q, grant_id_d;

    logic [NUM_PORTS-1:0]  pick_grant;
    logic [PORT_ID_W-1:0]  pick_idx;
    logic                  pick_any;
    logic                  transfer;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_ID_W (PORT_ID_W)
    ) u_rr_picker (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .grant_any  (pick_any)
    );

    // Since ready is exactly the picker grant, any grant is a transfer.
    assign req_ready = rst ? '0 : pick_grant;
    assign transfer  = pick_any && !rst;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (pick_grant[k]) begin
                sel_addr = req_addr[k*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Address/data/id hold when idle; only the enable drops.
    always_comb begin
        last_grant_d = last_grant_q;
        wb_d         = wb_q;
        grant_id_d   = grant_id_q;
        wb_d.en      = 1'b0;
        if (transfer) begin
            last_grant_d = pick_idx;
            grant_id_d   = pick_idx;
            wb_d.addr    = sel_addr;
            wb_d.data    = sel_data;
            wb_d.en      = !is_zero_reg(sel_addr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= LAST_GRANT_RST;
            wb_q         <= '0;
            grant_id_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wb_q         <= wb_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign write_en   = wb_q.en;
    assign write_addr = wb_q.addr;
    assign write_data = wb_q.data;
    assign grant_id   = grant_id_q;

    // A write is pending if it is still presented by a requester or is
    // sitting in the output register this cycle. Register 0 never hits.
    always_comb begin
        query_hit_1 = 1'b0;
        query_hit_2 = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (req_valid[k] && (req_addr[k*REG_ADDR_W +: REG_ADDR_W] == query_addr_1))
                query_hit_1 = 1'b1;
            if (req_valid[k] && (req_addr[k*REG_ADDR_W +: REG_ADDR_W] == query_addr_2))
                query_hit_2 = 1'b1;
        end
        if (wb_q.en && (wb_q.addr == query_addr_1))
            query_hit_1 = 1'b1;
        if (wb_q.en && (wb_q.addr == query_addr_2))
            query_hit_2 = 1'b1;
        if (is_zero_reg(query_addr_1))
            query_hit_1 = 1'b0;
        if (is_zero_reg(query_addr_2))
            query_hit_2 = 1'b0;
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//   Directed bench for reg_write_arbiter (3 ports). Inputs change 1 ns
//   after a rising edge; combinational outputs are sampled 1 ns later and
//   registered outputs 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

    localparam int NP = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   req_valid;
    logic [NP-1:0]   req_ready;
    logic [NP*5-1:0] req_addr;
    logic [NP*32-1:0] req_data;
    logic            write_en;
    logic [4:0]      write_addr;
    logic [31:0]     write_data;
    logic [IW-1:0]   grant_id;
    logic [4:0]      query_addr_1;
    logic [4:0]      query_addr_2;
    logic            query_hit_1;
    logic            query_hit_2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .NUM_PORTS (NP),
        .PORT_ID_W (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .write_en     (write_en),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .grant_id     (grant_id),
        .query_addr_1 (query_addr_1),
        .query_addr_2 (query_addr_2),
        .query_hit_1  (query_hit_1),
        .query_hit_2  (query_hit_2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input logic [4:0] a, input logic [31:0] d);
        req_addr[k*5 +: 5]   = a;
        req_data[k*32 +: 32] = d;
    endtask

    task automatic chk_wb(input string tag, input logic en, input logic [4:0] a,
                          input logic [31:0] d, input logic [IW-1:0] g);
        chk({tag, "_en"},   32'(write_en),   32'(en));
        chk({tag, "_addr"}, 32'(write_addr), 32'(a));
        chk({tag, "_data"}, write_data,      d);
        chk({tag, "_gid"},  32'(grant_id),   32'(g));
    endtask

    initial begin
        req_valid    = '0;
        req_addr     = '0;
        req_data     = '0;
        query_addr_1 = '0;
        query_addr_2 = '0;

        // Reset state, with requests presented to show ready stays low.
        rst       = 1'b1;
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk_wb("rst", 1'b0, 5'd0, 32'h0, 2'd0);
        req_valid = '0;
        rst       = 1'b0;

        // Port 1 alone, addr 5.
        set_port(1, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b010;
        #1;
        chk("p1_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk_wb("p1_wb", 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);

        // Idle 10 cycles: enable drops, the rest holds.
        repeat (10) tick();
        chk_wb("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF, 2'd1);

        // Ports 0 and 2 after a grant to 1: port 2 first.
        set_port(0, 5'd3, 32'h30);
        set_port(2, 5'd9, 32'h90);
        req_valid = 3'b101;
        #1;
        chk("p02_ready_a", 32'(req_ready), 32'h4);
        tick();
        req_valid = 3'b001;
        chk_wb("p02_wb_a", 1'b1, 5'd9, 32'h90, 2'd2);
        #1;
        chk("p02_ready_b", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk_wb("p02_wb_b", 1'b1, 5'd3, 32'h30, 2'd0);

        // Write to register 0 is accepted, then dropped; no hazard.
        set_port(0, 5'd0, 32'h1234);
        req_valid    = 3'b001;
        query_addr_1 = 5'd0;
        #1;
        chk("r0_ready", 32'(req_ready), 32'h1);
        chk("r0_hit_req", 32'(query_hit_1), 32'h0);
        tick();
        req_valid = '0;
        chk_wb("r0_wb", 1'b0, 5'd0, 32'h1234, 2'd0);
        chk("r0_hit_wb", 32'(query_hit_1), 32'h0);

        // All three valid for 6 cycles from reset: 0,1,2,0,1,2.
        rst = 1'b1;
        #1;
        chk("rst2_en", 32'(write_en), 32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < NP; k++) set_port(k, 5'(10 + k), 32'h100 + 32'(k));
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(1 << (i % 3)));
            tick();
            chk_wb($sformatf("rr_wb_%0d", i), 1'b1, 5'(10 + (i % 3)),
                   32'h100 + 32'(i % 3), 2'(i % 3));
        end
        req_valid = '0;
        tick();
        chk("rr_idle_en", 32'(write_en), 32'h0);

        // Port 2 granted, reset lands before its edge: nothing is written.
        set_port(2, 5'd12, 32'hCAFE);
        req_valid = 3'b100;
        #1;
        chk("rm_ready", 32'(req_ready), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("rm_ready_rst", 32'(req_ready), 32'h0);
        chk("rm_en_rst", 32'(write_en), 32'h0);
        tick();
        chk("rm_en_rst2", 32'(write_en), 32'h0);
        req_valid = '0;
        rst       = 1'b0;
        tick();
        chk_wb("rm_after", 1'b0, 5'd0, 32'h0, 2'd0);
        req_valid = 3'b111;
        #1;
        chk("rm_all_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk_wb("rm_all_wb", 1'b1, 5'd10, 32'h100, 2'd0);

        // Same address from ports 0 and 2: serialised, hazard held 3 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_port(0, 5'd7, 32'hA);
        set_port(1, 5'd7, 32'hC);
        set_port(2, 5'd7, 32'hB);
        req_valid    = 3'b101;
        query_addr_1 = 5'd3;
        query_addr_2 = 5'd7;
        #1;
        chk("sa_ready_a", 32'(req_ready), 32'h1);
        chk("sa_hit2_c0", 32'(query_hit_2), 32'h1);
        chk("sa_hit1_c0", 32'(query_hit_1), 32'h0);
        tick();
        req_valid = 3'b100;
        chk_wb("sa_wb_a", 1'b1, 5'd7, 32'hA, 2'd0);
        #1;
        chk("sa_ready_b", 32'(req_ready), 32'h4);
        chk("sa_hit2_c1", 32'(query_hit_2), 32'h1);
        tick();
        req_valid = '0;
        chk_wb("sa_wb_b", 1'b1, 5'd7, 32'hB, 2'd2);
        #1;
        chk("sa_hit2_c2", 32'(query_hit_2), 32'h1);
        tick();
        chk_wb("sa_end", 1'b0, 5'd7, 32'hB, 2'd2);
        chk("sa_hit2_c3", 32'(query_hit_2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 3, SHALL set the number of write-back requesters (range 2..4).
REQ-002 Parameter PORT_ID_W, default 2, SHALL set the width of the grant index.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_PORTS  SHALL mark, per port, that a write-back request is presented.
REQ-006 req_ready  output  NUM_PORTS  SHALL mark, per port, that the request is accepted this cycle.
REQ-007 req_addr  input  NUM_PORTS*5  SHALL carry the packed destination register addresses; port k uses bits [5k+4:5k].
REQ-008 req_data  input  NUM_PORTS*32  SHALL carry the packed write data; port k uses bits [32k+31:32k].
REQ-009 write_en  output  1  SHALL be the register-file write enable.
REQ-010 write_addr  output  5  SHALL be the register-file write address.
REQ-011 write_data  output  32  SHALL be the register-file write data.
REQ-012 grant_id  output  PORT_ID_W  SHALL identify the port whose write is on write_*.
REQ-013 query_addr_1, query_addr_2  input  5 each  SHALL be the decode-stage source addresses to check.
REQ-014 query_hit_1, query_hit_2  output  1 each  SHALL flag a pending write to the queried address.

Function
REQ-015 A transfer SHALL occur on port k when req_valid[k] and req_ready[k] are both high at a rising edge.
REQ-016 At most one req_ready bit SHALL be high per cycle.
REQ-017 req_ready SHALL depend only on req_valid and the round-robin pointer, never on req_addr or req_data.
REQ-018 Arbitration SHALL be round-robin: search starts at port (last_grant+1) mod NUM_PORTS; the first valid port wins.
REQ-019 last_grant SHALL update to the winner only on a transfer; it SHALL hold when there is no request.
REQ-020 An accepted request SHALL appear on write_addr/write_data/grant_id one cycle later (output register, latency 1).
REQ-021 write_en SHALL be high in that cycle, except when the accepted address is 0.
REQ-022 A write to register 0 SHALL be accepted and then dropped: write_en=0, and no hazard is reported for it.
REQ-023 With no transfer, write_en SHALL be 0 next cycle; write_addr, write_data and grant_id SHALL hold their last values.
REQ-024 Same-address requests from several ports in one cycle SHALL be serialised in round-robin order; the last-written value persists.
REQ-025 query_hit_n SHALL be combinational and SHALL be high when query_addr_n≠0 and it matches either:
  - any req_addr[k] with req_valid[k] high; or
  - write_addr while write_en is high.
REQ-026 A requester SHALL hold valid, addr and data stable until accepted; the block does not check this.

Reset
REQ-027 While rst is high, all registered state SHALL clear asynchronously:
  - write_en=0, write_addr=0, write_data=0, grant_id=0;
  - req_ready=0;
  - last_grant=NUM_PORTS-1, so that port 0 has first priority after reset.
REQ-028 Reset mid-transfer SHALL discard the output-register contents; no write_en pulse SHALL follow the reset release.
REQ-029 Arbitration SHALL resume on the first rising edge after rst falls.

Structure
REQ-030 REG_ADDR_W (5) and DATA_W (32) SHALL come from the shared bus-definition include.
REQ-031 NUM_PORTS and PORT_ID_W defaults SHALL sit with them in the shared definitions.
REQ-032 The round-robin picker SHALL be one sub-module, rr_picker: inputs req vector and last_grant; outputs one-hot grant and index.
REQ-033 The output register and hazard compare SHALL live in reg_write_arbiter itself.

Verification
REQ-034 Port 1 alone requests, valid=1, addr=5, data=0xDEADBEEF -> same cycle ready[1]=1; next cycle write_en=1, write_addr=5, write_data=0xDEADBEEF, grant_id=1.
REQ-035 All three ports hold valid for 6 cycles from reset -> grant order 0,1,2,0,1,2; write_en=1 in all 6 following cycles.
REQ-036 Port 0 requests addr=0, data=0x1234 -> ready[0]=1; next cycle write_en=0; query_addr_1=0 gives query_hit_1=0.
REQ-037 Ports 0 and 2 both request addr=7 (data 0xA, 0xB), query_addr_2=7 -> query_hit_2=1 for 3 cycles; writes issue 0xA then 0xB; hit clears after the last write.
REQ-038 Port 2 accepted, then rst pulses in the following cycle before its write -> write_en=0 throughout and after reset; next all-valid cycle grants port 0.
REQ-039 No valid for 10 cycles after grant to port 1, then ports 0 and 2 request -> port 2 wins first.
